// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU program-counter path:
// FSM state encoding, exception cause codes and default vectors.
package cpu_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_EXC = 1'b1
  } pc_state_e;

  localparam logic [1:0] CAUSE_OVF   = 2'd0;
  localparam logic [1:0] CAUSE_OPC   = 2'd1;
  localparam logic [1:0] CAUSE_DIV0  = 2'd2;
  localparam logic [1:0] CAUSE_ALIGN = 2'd3;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_BASE  = 32'h0000_00F0;

  // Word offset of a cause inside the exception vector table.
  function automatic logic [3:0] trap_ofs(input logic [1:0] cause);
    return {cause, 2'b00};
  endfunction

endpackage

// File: rtl/pc_src_sel.sv
// NSRC-way next-PC source select; flags out-of-range selectors and
// targets that are not word aligned.
module pc_src_sel #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SEL_W = $clog2(NSRC)
) (
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [NSRC*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]      nxt_o,
  output logic                  valid_o
);

  logic in_range;

  always_comb begin
    nxt_o = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel_i == SEL_W'(i)) nxt_o = data_i[i*WIDTH +: WIDTH];
    end
  end

  // With a non-power-of-two NSRC the selector can address missing sources.
  assign in_range = ({1'b0, sel_i} < (SEL_W+1)'(NSRC));
  assign valid_o  = in_range & (nxt_o[1:0] == 2'b00);

endmodule

// File: rtl/pc_unit_param.sv
// Program-counter unit: PC/EPC registers, next-PC update, exception
// redirect, misaligned-target trapping and ERET.
module pc_unit_param
  import cpu_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               NSRC      = 4,
  parameter int               SEL_W     = $clog2(NSRC),
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_BASE  = WIDTH'(DEF_EXC_BASE),
  parameter int               EPC_OFS   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [SEL_W-1:0]      src_sel,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic                  pc_write,
  input  logic                  pc_write_cond,
  input  logic                  branch_taken,
  input  logic                  exc_req,
  input  logic [1:0]            exc_cause,
  input  logic                  eret,
  output logic [WIDTH-1:0]      pc_out,
  output logic [WIDTH-1:0]      epc_out,
  output logic                  exc_active,
  output logic                  misalign
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             mis_q, mis_d;

  logic [WIDTH-1:0] nxt;
  logic             nxt_valid;
  logic             wr_en;
  logic [WIDTH-1:0] epc_cap;

  function automatic logic [WIDTH-1:0] trap_vec(input logic [1:0] cause);
    return EXC_BASE + WIDTH'(trap_ofs(cause));
  endfunction

  pc_src_sel #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SEL_W (SEL_W)
  ) u_src_sel (
    .sel_i   (src_sel),
    .data_i  (src_data),
    .nxt_o   (nxt),
    .valid_o (nxt_valid)
  );

  assign wr_en   = pc_write | (pc_write_cond & branch_taken);
  assign epc_cap = pc_q - WIDTH'(EPC_OFS);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    mis_d   = mis_q;
    case (state_q)
      ST_RUN: begin
        if (exc_req) begin
          epc_d   = epc_cap;
          pc_d    = trap_vec(exc_cause);
          state_d = ST_EXC;
        end else if (eret) begin
          pc_d  = epc_q;
          mis_d = 1'b0;
        end else if (wr_en) begin
          if (nxt_valid) begin
            pc_d = nxt;
          end else begin
            // Bad target never reaches PC; trap as an alignment fault instead.
            mis_d   = 1'b1;
            epc_d   = epc_cap;
            pc_d    = trap_vec(CAUSE_ALIGN);
            state_d = ST_EXC;
          end
        end
      end
      ST_EXC:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_out     = pc_q;
  assign epc_out    = epc_q;
  assign exc_active = (state_q == ST_EXC);
  assign misalign   = mis_q;

endmodule

// File: tb/tb_pc_unit_param.sv
// Bench for pc_unit_param: directed literal checks, then randomized traffic
// compared every cycle against a behavioural model of the PC unit.
module tb_pc_unit_param;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  src_sel = '0;
  logic [31:0] src [4];
  logic [127:0] src_data;
  logic        pc_write = 0, pc_write_cond = 0, branch_taken = 0;
  logic        exc_req = 0, eret = 0;
  logic [1:0]  exc_cause = '0;
  logic [31:0] pc_out, epc_out;
  logic        exc_active, misalign;

  // Second instance with a non-power-of-two source count.
  logic [1:0]  b_sel = '0;
  logic [95:0] b_data = '0;
  logic        b_pc_write = 0;
  logic [31:0] b_pc, b_epc;
  logic        b_exc, b_mis;

  int chk_cnt = 0;
  int pass_cnt = 0;
  bit check_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_pc, m_epc;
  logic        m_mis, m_exc;

  always #5 clk = ~clk;

  assign src_data = {src[3], src[2], src[1], src[0]};

  pc_unit_param dut (
    .clk(clk), .reset_n(reset_n), .src_sel(src_sel), .src_data(src_data),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_taken(branch_taken),
    .exc_req(exc_req), .exc_cause(exc_cause), .eret(eret),
    .pc_out(pc_out), .epc_out(epc_out), .exc_active(exc_active), .misalign(misalign)
  );

  pc_unit_param #(.NSRC(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .src_sel(b_sel), .src_data(b_data),
    .pc_write(b_pc_write), .pc_write_cond(1'b0), .branch_taken(1'b0),
    .exc_req(1'b0), .exc_cause(2'b00), .eret(1'b0),
    .pc_out(b_pc), .epc_out(b_epc), .exc_active(b_exc), .misalign(b_mis)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: a trap in progress swallows the cycle; otherwise exc_req beats
  // eret beats a PC write, and a bad write target becomes an alignment trap.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc <= 32'h0; m_epc <= 32'h0; m_mis <= 1'b0; m_exc <= 1'b0;
    end else if (m_exc) begin
      m_exc <= 1'b0;
    end else if (exc_req) begin
      m_epc <= m_pc - 32'd4;
      m_pc  <= 32'hF0 + 32'(exc_cause) * 32'd4;
      m_exc <= 1'b1;
    end else if (eret) begin
      m_pc  <= m_epc;
      m_mis <= 1'b0;
    end else if (pc_write || (pc_write_cond && branch_taken)) begin
      if (src[src_sel] % 4 == 0) begin
        m_pc <= src[src_sel];
      end else begin
        m_mis <= 1'b1;
        m_epc <= m_pc - 32'd4;
        m_pc  <= 32'hF0 + 32'd12;
        m_exc <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_pc", pc_out, m_pc);
      chk("cyc_epc", epc_out, m_epc);
      chk("cyc_exc", 32'(exc_active), 32'(m_exc));
      chk("cyc_mis", 32'(misalign), 32'(m_mis));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    pc_write = 0; pc_write_cond = 0; branch_taken = 0; exc_req = 0; eret = 0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) src[i] = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_epc", epc_out, 32'h0);
    chk("rst_mis", 32'(misalign), 32'h0);
    chk("rst_exc", 32'(exc_active), 32'h0);
    reset_n = 1'b1;
    check_en = 1'b1;

    pc_write = 1; src_sel = 1; src[1] = 32'h40;
    step(); chk("wr_sel1", pc_out, 32'h40);
    chk("model_sel1", m_pc, 32'h40);
    src_sel = 3; src[3] = 32'h1000;
    step(); chk("wr_sel3", pc_out, 32'h1000);

    idle(); pc_write_cond = 1; branch_taken = 0; src_sel = 2; src[2] = 32'h80;
    step(); chk("br_not_taken", pc_out, 32'h1000);
    branch_taken = 1;
    step(); chk("br_taken", pc_out, 32'h80);

    idle(); pc_write = 1; src_sel = 0; src[0] = 32'h44;
    step(); chk("wr_44", pc_out, 32'h44);

    idle(); exc_req = 1; exc_cause = 2'd1;
    step();
    chk("exc_pc", pc_out, 32'hF4);
    chk("exc_epc", epc_out, 32'h40);
    chk("exc_active", 32'(exc_active), 32'h1);
    chk("model_exc_epc", m_epc, 32'h40);
    exc_cause = 2'd2;
    step();
    chk("exc_nested_pc", pc_out, 32'hF4);
    chk("exc_nested_epc", epc_out, 32'h40);
    chk("exc_one_cycle", 32'(exc_active), 32'h0);

    idle(); eret = 1; pc_write = 1; src_sel = 1;
    step(); chk("eret_pc", pc_out, 32'h40);

    idle(); pc_write = 1; src_sel = 0; src[0] = 32'h102;
    step();
    chk("mis_flag", 32'(misalign), 32'h1);
    chk("mis_epc", epc_out, 32'h3C);
    chk("mis_pc", pc_out, 32'hFC);
    chk("mis_exc", 32'(exc_active), 32'h1);
    idle();
    step(); chk("mis_sticky", 32'(misalign), 32'h1);
    eret = 1;
    step();
    chk("eret_clr_mis", 32'(misalign), 32'h0);
    chk("eret_pc2", pc_out, 32'h3C);
    idle();

    // Three-source instance: selector 3 has no source behind it.
    b_data = {32'h300, 32'h200, 32'h100};
    b_sel = 2; b_pc_write = 1;
    step(); chk("n3_sel2", b_pc, 32'h300);
    b_sel = 3;
    step();
    chk("n3_bad_mis", 32'(b_mis), 32'h1);
    chk("n3_bad_pc", b_pc, 32'hFC);
    chk("n3_bad_epc", b_epc, 32'h2FC);
    b_pc_write = 0;

    // Asynchronous reset mid-cycle, with a trap pending.
    pc_write = 1; src_sel = 0; src[0] = 32'h81;
    @(posedge clk); #2;
    chk("pre_rst_exc", 32'(exc_active), 32'h1);
    idle();
    reset_n = 1'b0; #1;
    chk("async_pc", pc_out, 32'h0);
    chk("async_epc", epc_out, 32'h0);
    chk("async_mis", 32'(misalign), 32'h0);
    chk("async_exc", 32'(exc_active), 32'h0);
    chk("async_n3_pc", b_pc, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        src[i] = $urandom & 32'hFFFC;
        if ($urandom_range(0, 7) == 0) src[i][1:0] = 2'($urandom_range(1, 3));
      end
      src_sel       = 2'($urandom);
      pc_write      = ($urandom_range(0, 3) == 0);
      pc_write_cond = ($urandom_range(0, 2) == 0);
      branch_taken  = $urandom_range(0, 1) == 1;
      exc_req       = ($urandom_range(0, 9) == 0);
      exc_cause     = 2'($urandom);
      eret          = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
